// File: rtl/fc_neuron_mac_if.sv
// Bus bundle for fc_neuron_mac: the shared weight/pixel ROM read port and
// the valid/ready result port toward the next layer.
interface fc_neuron_mac_if #(
    parameter int IDX_W = 12
);
    logic [IDX_W-1:0] rom_index;
    logic [31:0]      w_data;
    logic [31:0]      px_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result;

    modport master (
        output rom_index,
        input  w_data,
        input  px_data,
        output out_valid,
        input  out_ready,
        output result
    );

    modport slave (
        input  rom_index,
        output w_data,
        output px_data,
        input  out_valid,
        output out_ready,
        input  result
    );
endinterface

// File: rtl/fc_neuron_mac.sv
// Q16.16 multiply-accumulate engine for one fully-connected neuron.
// Define FC_RELU_EN to clamp negative results to zero (hidden-layer neurons).
module fc_neuron_mac #(
    parameter int N_INPUTS  = 784,
    parameter int IDX_W     = 12,
    parameter int FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] bias,
    output logic        busy,
    fc_neuron_mac_if.master bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_INPUTS - 1);
    localparam logic signed [63:0] MAX_V   = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] MIN_V   = 64'shFFFF_FFFF_8000_0000;

    logic [1:0]          state;
    logic                armed;
    logic [IDX_W-1:0]    cnt;
    logic signed [63:0]  acc;
    logic [31:0]         result_q;

    logic signed [31:0]  w_s;
    logic signed [31:0]  px_s;
    logic signed [63:0]  prod;
    logic signed [63:0]  term;
    logic signed [63:0]  sum;
    logic [31:0]         sat;

    assign w_s  = bus.w_data;
    assign px_s = bus.px_data;

    // Low 64 bits of a product do not depend on signedness once both
    // operands are sign-extended to the full width.
    assign prod = {{32{w_s[31]}}, w_s} * {{32{px_s[31]}}, px_s};
    assign term = prod >>> FRAC_BITS;
    assign sum  = acc + term;

    always_comb begin
        sat = sum[31:0];
        if (sum > MAX_V)
            sat = 32'h7FFF_FFFF;
        else if (sum < MIN_V)
            sat = 32'h8000_0000;
`ifdef FC_RELU_EN
        if (sat[31])
            sat = 32'h0000_0000;
`else
        sat = sat;
`endif
    end

    // An accepted start first arms the engine and loads bias; the next edge
    // enters ACCUM, which gives one result per N_INPUTS+3 cycles back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            armed    <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (armed) begin
                        state <= ST_ACCUM;
                        armed <= 1'b0;
                    end else if (start) begin
                        armed <= 1'b1;
                        cnt   <= '0;
                        acc   <= {{32{bias[31]}}, bias};
                    end
                end
                ST_ACCUM: begin
                    acc <= sum;
                    if (cnt == LAST_IDX) begin
                        result_q <= sat;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready)
                        state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    armed <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_index = cnt;
    assign bus.result    = result_q;
    assign bus.out_valid = (state == ST_DONE);
    assign busy          = (state == ST_ACCUM) || (state == ST_DONE);

endmodule

// File: doc/fc_neuron_mac.md
# fc_neuron_mac

Sequential multiply-accumulate engine for one fully-connected neuron of the digit classifier. It acts as the reader for the weight and pixel ROMs. On each step it drives one shared index, takes the weight and the activation that come back, and accumulates their Q16.16 product. After the last input it adds the bias, saturates, optionally applies ReLU, and offers the 32-bit result on a valid/ready port to the next layer.

## Interface
Parameters:
- `N_INPUTS`, default 784: number of inputs (terms) per neuron, at least 1.
- `IDX_W`, default 12: index width; must satisfy 2^IDX_W ≥ N_INPUTS.
- `FRAC_BITS`, default 16: fractional bits of the fixed-point format.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: begin one neuron evaluation; sampled only in IDLE.
- `bias`  in  32: signed Q16.16 bias; captured on the accepted start.
- `rom_index`  out  IDX_W: shared index to the weight ROM and the pixel ROM.
- `w_data`  in  32: signed Q16.16 weight; combinational ROM response to `rom_index`.
- `px_data`  in  32: signed Q16.16 activation; combinational ROM response to `rom_index`.
- `busy`  out  1: high in ACCUM and DONE.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: downstream accepts the result.
- `result`  out  32: signed Q16.16 neuron output.

## Operation
- States and transitions:
  - IDLE → ACCUM when `start`=1. The counter is cleared to 0 and the accumulator is loaded with `bias` sign-extended to 64 bits.
  - ACCUM: `rom_index` equals the counter. On each edge, acc += (w_data × px_data) >>> FRAC_BITS, and the counter increments.
  - ACCUM → DONE on the edge that consumes index N_INPUTS-1. On that same edge, `result` is loaded from the final sum (accumulator plus the last product).
  - DONE → IDLE on the edge where `out_valid` and `out_ready` are both 1.
- Arithmetic:
  - The product is a full 64-bit signed multiply.
  - The right shift is arithmetic, so it truncates toward −∞.
  - The accumulator is 64-bit signed; 784 terms of at most 48 bits cannot overflow it.
  - The final sum saturates to the signed 32-bit range: 0x7FFFFFFF or 0x80000000.
- `start` is ignored in ACCUM and DONE. A `start` in the same cycle as the DONE handshake is also ignored; a new run needs `start` while in IDLE.
- In DONE, `result` and `out_valid` are held stable until the handshake completes. `rom_index` holds its last value.
- Reset mid-operation aborts the run immediately; there is no partial output.

## Timing
- Reset values:
  - state = IDLE
  - counter = 0, so `rom_index` = 0
  - accumulator = 0
  - `result` = 0
  - `busy` = 0
  - `out_valid` = 0
- With `start` sampled at edge E:
  - ACCUM is entered at E+1.
  - Indices 0..N_INPUTS-1 are consumed at edges E+2..E+N_INPUTS+1.
  - `out_valid` = 1 after edge E+N_INPUTS+1.
  - Latency from start to result is N_INPUTS+1 cycles.
- ROM data must settle within the same cycle that `rom_index` changes (combinational ROM).
- Back-to-back throughput is one result per N_INPUTS+3 cycles when `out_ready` is held at 1.

## Configuration
- `FC_RELU_EN`:
  - Defined: a negative saturated sum is replaced by 0, so `result` ≥ 0 always (hidden-layer neurons).
  - Undefined: `result` is the raw saturated signed sum (output-layer logits).

## Test plan
All scenarios use N_INPUTS=4 and FRAC_BITS=16.
1. px=0x00010000, w=0x00008000, bias=0, `start` at edge E → `out_valid` rises after edge E+5 with `result`=0x00020000; `busy` is high from E+1.
2. px=0x00010000, w=0xFFFF0000, bias=0 → `result`=0x00000000 with `FC_RELU_EN` defined; 0xFFFC0000 without it.
3. px=w=0x7FFFFFFF, bias=0x7FFFFFFF → `result`=0x7FFFFFFF (positive saturation). With w=0x80000001 and `FC_RELU_EN` undefined → `result`=0x80000000.
4. w=0, bias=0x00018000 → `result`=0x00018000. Hold `out_ready`=0 for 10 cycles while pulsing `start` → `result`, `out_valid` and `rom_index`=3 stay stable; one `out_ready` pulse returns the block to IDLE.
5. Assert `rst_n`=0 while `rom_index`=2 → all outputs read 0 and state is IDLE. After release, a fresh `start` using the values from scenario 1 yields 0x00020000 with the scenario-1 latency.
6. Two back-to-back runs with `out_ready`=1 and `start` reasserted in IDLE → second `out_valid` comes 7 cycles after the first; a `start` held during the handshake cycle is ignored.
